// File: rtl/fsm_bit_serializer_pkg.sv
// Package fsm_ser_pkg: shared types and default parameters for the bit serializer.
//   ser_state_t  : control FSM state encoding
//   DATA_W_DEF   : default word width
//   MSB_FIRST_DEF: default bit order (1 = MSB first)
//   GAP_CYC_DEF  : default idle cycles inserted after each word
package fsm_ser_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_PAR   = 2'b10,
        S_GAP   = 2'b11
    } ser_state_t;

    localparam int DATA_W_DEF    = 8;
    localparam int MSB_FIRST_DEF = 1;
    localparam int GAP_CYC_DEF   = 0;

endpackage

// File: rtl/fsm_bit_serializer_if.sv
// Interface bundling the word-input handshake and the serial-output signals.
//   din, din_valid, din_ready       : parallel word handshake (producer -> serializer)
//   bit_out, bit_valid              : serial bit and its qualifier (feeds FSM input A)
//   word_done                       : pulse on the final bit of a word
//   busy                            : serializer is not idle
// Modports: master = producer / observer side, slave = serializer side.
interface fsm_bit_serializer_if
    import fsm_ser_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              din_ready;
    logic              bit_out;
    logic              bit_valid;
    logic              word_done;
    logic              busy;

    modport master (
        output din, din_valid,
        input  din_ready, bit_out, bit_valid, word_done, busy
    );

    modport slave (
        input  din, din_valid,
        output din_ready, bit_out, bit_valid, word_done, busy
    );
endinterface

// File: rtl/fsm_bit_serializer.sv
// fsm_bit_serializer: accepts parallel words over valid/ready and shifts them out one
// bit per clock. Optional even-parity bit appended when SER_PARITY_EN is defined.
// Ports:
//   i_clk : clock, all state updates on the rising edge
//   i_rst : synchronous active-high reset
//   bus   : fsm_bit_serializer_if.slave (din/din_valid/din_ready, bit_out/bit_valid,
//           word_done, busy)
// Configuration macro: SER_PARITY_EN (adds S_PAR and a parity bit after the data bits).
//
// state   | meaning
// S_IDLE  | waiting for a word, din_ready=1
// S_SHIFT | emitting data bits, counter counts DATA_W-1 down to 0
// S_PAR   | emitting the even-parity bit (SER_PARITY_EN only)
// S_GAP   | GAP_CYC idle cycles after a word, bit_valid=0
module fsm_bit_serializer
    import fsm_ser_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MSB_FIRST = MSB_FIRST_DEF,
    parameter int GAP_CYC   = GAP_CYC_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    fsm_bit_serializer_if.slave  bus
);

    localparam int                CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(DATA_W - 1);
    localparam logic [7:0]        GAP_LOAD = (GAP_CYC > 0) ? 8'(GAP_CYC - 1) : 8'd0;

    ser_state_t        r_state;
    ser_state_t        w_state_nxt;
    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_cnt;
    logic [7:0]        r_gap;
    logic              w_accept;
    logic              w_last_data;
    logic              w_final_bit;
    logic              w_din_ready;
    logic              w_bit_out;
    logic              w_bit_valid;
    logic              w_word_done;
    logic              w_busy;
`ifdef SER_PARITY_EN
    logic              r_par;
`endif

    assign w_last_data = (r_state == S_SHIFT) && (r_cnt == '0);
`ifdef SER_PARITY_EN
    assign w_final_bit = (r_state == S_PAR);
`else
    assign w_final_bit = w_last_data;
`endif
    // A new word may be taken on the final bit only when no gap follows, which lets
    // back-to-back words stream without a bubble.
    assign w_din_ready = (r_state == S_IDLE) || ((GAP_CYC == 0) && w_final_bit);
    assign w_accept    = bus.din_valid && w_din_ready;

    // state register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // datapath: shift register, bit counter, gap counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_gap   <= '0;
`ifdef SER_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_shift <= bus.din;
                r_cnt   <= CNT_LOAD;
`ifdef SER_PARITY_EN
                r_par   <= ^bus.din;
`endif
            end else if (r_state == S_SHIFT) begin
                if (MSB_FIRST != 0) r_shift <= {r_shift[DATA_W-2:0], 1'b0};
                else                r_shift <= {1'b0, r_shift[DATA_W-1:1]};
                if (r_cnt != '0)    r_cnt   <= r_cnt - 1'b1;
            end
            // Preloaded outside S_GAP so the first gap cycle already sees GAP_CYC-1.
            if (r_state != S_GAP)   r_gap <= GAP_LOAD;
            else if (r_gap != 8'd0) r_gap <= r_gap - 8'd1;
        end
    end

    // next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (r_cnt == '0) begin
`ifdef SER_PARITY_EN
                    w_state_nxt = S_PAR;
`else
                    if (GAP_CYC > 0)   w_state_nxt = S_GAP;
                    else if (w_accept) w_state_nxt = S_SHIFT;
                    else               w_state_nxt = S_IDLE;
`endif
                end
            end
`ifdef SER_PARITY_EN
            S_PAR: begin
                if (GAP_CYC > 0)   w_state_nxt = S_GAP;
                else if (w_accept) w_state_nxt = S_SHIFT;
                else               w_state_nxt = S_IDLE;
            end
`endif
            S_GAP: begin
                if (r_gap == 8'd0) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // output logic (Moore on registered state; bit_out forced low when not valid)
    always_comb begin
        w_bit_out   = 1'b0;
        w_bit_valid = 1'b0;
        w_busy      = (r_state != S_IDLE);
        w_word_done = w_final_bit;
        if (r_state == S_SHIFT) begin
            w_bit_valid = 1'b1;
            w_bit_out   = (MSB_FIRST != 0) ? r_shift[DATA_W-1] : r_shift[0];
        end
`ifdef SER_PARITY_EN
        if (r_state == S_PAR) begin
            w_bit_valid = 1'b1;
            w_bit_out   = r_par;
        end
`endif
    end

    assign bus.din_ready = w_din_ready;
    assign bus.bit_out   = w_bit_out;
    assign bus.bit_valid = w_bit_valid;
    assign bus.word_done = w_word_done;
    assign bus.busy      = w_busy;

endmodule
